// File: rtl/riscv_pkg.sv
// Shared RV32 constants, the load-queue entry type and the load extension helper
// used by the writeback stage.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } ld_entry_t;

    // Undefined funct3 codes fall through to a whole-word write.
    function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   ld_extend = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  ld_extend = {{(XLEN-8){1'b0}}, b};
            F3_LH:   ld_extend = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  ld_extend = {{(XLEN-16){1'b0}}, h};
            default: ld_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO of extended load results; exposes per-entry valid bits and
// destinations so the top can build the pending-destination mask.
module wb_load_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  ld_entry_t                     push_data_i,
    input  logic                          pop_i,
    output ld_entry_t                     head_o,
    output logic [CW-1:0]                 count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0]              vld_o,
    output logic [DEPTH-1:0][REG_AW-1:0]  rd_o
);

    ld_entry_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [AW-1:0]         wp_q, rp_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push, pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;
    assign vld_o   = vld_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) rd_o[i] = mem_q[i].rd;
    end

    always_comb begin
        vld_d = vld_q;
        if (pop)  vld_d[rp_q] = 1'b0;
        if (push) vld_d[wp_q] = 1'b1;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
            vld_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[wp_q] <= push_data_i;
                wp_q        <= wp_q + AW'(1);
            end
            if (pop) rp_q <= rp_q + AW'(1);
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: arbitrates the ALU path and the queued load path onto the single
// register-file write port and exports a pending-destination mask for decode.
module wb_writer
    import riscv_pkg::*;
#(
    parameter int LD_DEPTH = 2,
    parameter int XLEN     = riscv_pkg::XLEN,
    localparam int CW = $clog2(LD_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_word,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_byte_off,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     pending_mask,
    output logic [CW-1:0]   ld_count
);

    ld_entry_t                          push_ent, head;
    logic                               full, empty, push, pop, alu_we;
    logic [LD_DEPTH-1:0]                ent_vld;
    logic [LD_DEPTH-1:0][REG_AW-1:0]    ent_rd;
    logic                               wb_en_q, wb_en_d;
    logic [4:0]                         wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]                    wb_data_q, wb_data_d;

    // ld_ready looks only at the registered count, never at this cycle's dequeue.
    assign ld_ready = !full;
    assign push     = ld_valid && ld_ready && (ld_rd != '0);
    assign alu_we   = alu_valid && (alu_rd != '0);
    assign pop      = !alu_we && !empty;

    assign push_ent.rd   = ld_rd;
    assign push_ent.data = ld_extend(ld_word, ld_funct3, ld_byte_off);

    wb_load_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (ld_count),
        .full_o      (full),
        .empty_o     (empty),
        .vld_o       (ent_vld),
        .rd_o        (ent_rd)
    );

    always_comb begin
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (alu_we) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = alu_rd;
            wb_data_d = alu_data;
        end else if (pop) begin
            wb_en_d   = 1'b1;
            wb_rd_d   = head.rd;
            wb_data_d = head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LD_DEPTH; i++)
            if (ent_vld[i]) pending_mask[ent_rd[i]] = 1'b1;
        if (wb_en_q) pending_mask[wb_rd_q] = 1'b1;
        pending_mask[0] = 1'b0;
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

endmodule
